// File: rtl/serial_bcd_adder_ctrl.sv
// serial_bcd_adder_ctrl: digit-serial BCD adder that time-shares one BCD digit adder, LSD first
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : accept A, B, C_in and begin an addition (ignored while busy)
//   A, B  : BCD operands, digit 0 in bits [3:0]
//   C_in  : carry into digit 0
//   busy  : high while digits are processed
//   done  : one-cycle result-valid pulse
//   S     : BCD sum (partial digits visible while busy)
//   C_out : decimal carry out of the top digit
//   err   : an accepted operand had a digit above 9

module bcd_digit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] w_bin;
    always_comb begin
        w_bin = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        cout  = w_bin > 5'd9;
        s     = cout ? w_bin[3:0] + 4'd6 : w_bin[3:0];
    end
endmodule

module serial_bcd_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  C_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   S,
    output logic                  C_out,
    output logic                  err
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [1:0] IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2;

    logic [1:0]          r_state;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic [4*DIGITS-1:0] r_a, r_b, r_s;
    logic                r_cout, r_err;
    logic [3:0]          w_sum;
    logic                w_carry, w_bad, w_last, w_accept;

    bcd_digit_adder u_add (
        .a    (r_a[{r_idx, 2'b00} +: 4]),
        .b    (r_b[{r_idx, 2'b00} +: 4]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_carry)
    );

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end

    assign w_last   = r_idx == IW'(DIGITS - 1);
    assign w_accept = start && r_state != ADD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_state <= ADD;
            r_idx   <= '0;
            r_carry <= C_in;
            r_a     <= A;
            r_b     <= B;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_err   <= w_bad;
        end else if (r_state == ADD) begin
            r_s[{r_idx, 2'b00} +: 4] <= w_sum;
            r_carry <= w_carry;
            // index stops at the last digit instead of wrapping
            r_idx   <= w_last ? r_idx : r_idx + 1'b1;
            r_cout  <= w_last ? w_carry : r_cout;
            r_state <= w_last ? DONE : ADD;
        end else begin
            r_state <= IDLE;
        end
    end

    assign busy  = r_state == ADD;
    assign done  = r_state == DONE;
    assign S     = r_s;
    assign C_out = r_cout;
    assign err   = r_err;
endmodule

// File: tb/tb_serial_bcd_adder_ctrl.sv
// tb_serial_bcd_adder_ctrl: vector table plus scoreboard check of the serial BCD adder
module tb_serial_bcd_adder_ctrl;
    localparam int DIGITS = 4;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, C_in = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        busy, done, C_out, err;
    logic [15:0] S;

    serial_bcd_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C_in(C_in),
        .busy(busy), .done(done), .S(S), .C_out(C_out), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        ci;
        logic [15:0] s;
        logic        c, e, chk_s;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c, e, chk_s;
    } exp_t;

    vec_t vt[7];
    exp_t sb[$];
    int   errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int   va = 0, vb = 0, sum;
        exp_t r;
        for (int i = 3; i >= 0; i--) begin
            va = va * 10 + int'(a[4*i +: 4]);
            vb = vb * 10 + int'(b[4*i +: 4]);
        end
        sum = va + vb + int'(ci);
        r.c = sum >= 10000;
        sum = sum % 10000;
        for (int i = 0; i < 4; i++) begin
            r.s[4*i +: 4] = 4'(sum % 10);
            sum = sum / 10;
        end
        r.e = 1'b0;
        r.chk_s = 1'b1;
        return r;
    endfunction

    task automatic pop_cmp(input string name);
        exp_t x;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
            return;
        end
        x = sb.pop_front();
        if (x.chk_s) chk({name, "_S"}, S, x.s);
        chk({name, "_C_out"}, C_out, x.c);
        chk({name, "_err"}, err, x.e);
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input exp_t x);
        logic [15:0] held;
        @(negedge clk);
        A = a; B = b; C_in = ci; start = 1'b1;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0; A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom);
        chk({name, "_busy1"}, busy, 1);
        chk({name, "_err_early"}, err, x.e);
        for (int i = 2; i <= DIGITS; i++) begin
            @(negedge clk);
            chk({name, "_busy"}, {busy, done}, 2'b10);
        end
        @(negedge clk);
        chk({name, "_done"}, {busy, done}, 2'b01);
        held = S;
        pop_cmp(name);
        @(negedge clk);
        chk({name, "_idle"}, {busy, done}, 2'b00);
        chk({name, "_hold"}, S, held);
    endtask

    initial begin
        exp_t x;
        logic seen;
        vt[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1};
        vt[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1};
        vt[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};
        vt[4] = '{16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vt[5] = '{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1};
        vt[6] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

        #12;
        chk("reset_outputs", {busy, done, S, C_out, err}, 20'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {busy, done}, 2'b00);

        foreach (vt[i]) begin
            x = '{vt[i].s, vt[i].c, vt[i].e, vt[i].chk_s};
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].ci, x);
        end

        for (int n = 0; n < 4; n++) begin
            logic [15:0] ra, rb;
            logic rc;
            for (int d = 0; d < 4; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom);
            run_op($sformatf("rnd%0d", n), ra, rb, rc, model(ra, rb, rc));
        end

        // start held through ADD, operands changed mid-operation
        @(negedge clk);
        A = 16'h1234; B = 16'h5678; C_in = 1'b0; start = 1'b1;
        sb.push_back(model(16'h1234, 16'h5678, 1'b0));
        @(negedge clk);
        A = 16'h1111; B = 16'h2222;
        chk("hold_busy1", busy, 1);
        for (int i = 2; i <= DIGITS; i++) begin
            @(negedge clk);
            chk("hold_busy", {busy, done}, 2'b10);
        end
        @(negedge clk);
        chk("hold_done1", {busy, done}, 2'b01);
        pop_cmp("hold_op1");
        sb.push_back(model(16'h1111, 16'h2222, 1'b0));
        @(negedge clk);
        start = 1'b0;
        chk("hold_restart_busy", {busy, done}, 2'b10);
        for (int i = 2; i <= DIGITS; i++) begin
            @(negedge clk);
            chk("hold_busy2", {busy, done}, 2'b10);
        end
        @(negedge clk);
        chk("hold_done2", {busy, done}, 2'b01);
        pop_cmp("hold_op2");

        // reset in the middle of an addition
        @(negedge clk);
        A = 16'h1234; B = 16'h5678; C_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {busy, done, S, C_out, err}, 20'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= done;
        end
        chk("midrst_no_done", seen, 0);
        run_op("after_rst", 16'h4321, 16'h0789, 1'b1, model(16'h4321, 16'h0789, 1'b1));

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
